inv_sub_word_seq: RTL and testbench

INV_SUB_WORD_SEQ -- requirements
Module: inv_sub_word_seq

---
 rtl/inv_sub_word_seq.sv | 144 ++++++++++++++
 tb/tb_inv_sub_word_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_word_seq.sv
// rtl/inv_sub_word_seq.sv - sequential AES inverse SubWord, BYTES_PER_CYCLE bytes per clock

// Combinational AES inverse S-box lookup for one byte.
module inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [7:0] INV_TABLE [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign o_byte = INV_TABLE[i_byte];

endmodule

// Word byte k lives at bits [8k+7:8k]. Only BYTES_PER_CYCLE S-box lanes exist;
// they walk across the captured word, and the result is shown only once complete.
module inv_sub_word_seq #(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] lhs,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] o
);

  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4) begin : g_bad_bpc
    $error("inv_sub_word_seq: BYTES_PER_CYCLE must be 1, 2 or 4");
  end

  // Index step per cycle and the index of the final lane group (both mod 4).
  localparam logic [1:0] STEP     = 2'(BYTES_PER_CYCLE % 4);
  localparam logic [1:0] LAST_IDX = 2'((4 - BYTES_PER_CYCLE) % 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic [31:0] r_result;
  logic        r_i_ready;
  logic        r_o_valid;

  logic [1:0]  w_pos [BYTES_PER_CYCLE];
  logic [7:0]  w_in  [BYTES_PER_CYCLE];
  logic [7:0]  w_out [BYTES_PER_CYCLE];
  logic [31:0] w_result_nxt;
  logic        w_last;

  // One inverse S-box per lane, each fed from byte idx+j of the captured word.
  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
    assign w_pos[j] = r_idx + 2'(j);
    assign w_in[j]  = r_word[{w_pos[j], 3'b000} +: 8];
    inv_sbox u_inv_sbox (
      .i_byte (w_in[j]),
      .o_byte (w_out[j])
    );
  end

  assign w_last = (r_idx == LAST_IDX);

  // Merge this cycle's lane outputs into the result word at their byte positions.
  always_comb begin
    w_result_nxt = r_result;
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      w_result_nxt[{w_pos[j], 3'b000} +: 8] = w_out[j];
    end
  end

  // Control FSM with registered handshake outputs; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= 2'd0;
      r_word    <= 32'h0;
      r_result  <= 32'h0;
      r_i_ready <= 1'b0;
      r_o_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid && r_i_ready) begin
            r_word    <= lhs;
            r_idx     <= 2'd0;
            r_state   <= SUB;
            r_i_ready <= 1'b0;
          end else begin
            r_i_ready <= 1'b1;
          end
        end
        SUB: begin
          r_result <= w_result_nxt;
          r_idx    <= r_idx + STEP;
          if (w_last) begin
            r_state   <= DONE;
            r_o_valid <= 1'b1;
          end
        end
        DONE: begin
          if (o_ready) begin
            r_state   <= IDLE;
            r_o_valid <= 1'b0;
            r_i_ready <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_idx     <= 2'd0;
          r_i_ready <= 1'b0;
          r_o_valid <= 1'b0;
        end
      endcase
    end
  end

  assign i_ready = r_i_ready;
  assign o_valid = r_o_valid;
  assign o       = r_result;

endmodule

// File: tb/tb_inv_sub_word_seq.sv
// tb/tb_inv_sub_word_seq.sv - directed and round-trip bench for inv_sub_word_seq at 1, 2 and 4 bytes per cycle

module tb_inv_sub_word_seq;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lhs;
  logic        iv   [3];
  logic        ordy [3];
  logic        ir   [3];
  logic        ov   [3];
  logic [31:0] ow   [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inv_sub_word_seq #(.BYTES_PER_CYCLE(1)) u_bpc1 (
    .clk(clk), .rst(rst), .i_valid(iv[0]), .i_ready(ir[0]), .lhs(lhs),
    .o_valid(ov[0]), .o_ready(ordy[0]), .o(ow[0]));
  inv_sub_word_seq #(.BYTES_PER_CYCLE(2)) u_bpc2 (
    .clk(clk), .rst(rst), .i_valid(iv[1]), .i_ready(ir[1]), .lhs(lhs),
    .o_valid(ov[1]), .o_ready(ordy[1]), .o(ow[1]));
  inv_sub_word_seq #(.BYTES_PER_CYCLE(4)) u_bpc4 (
    .clk(clk), .rst(rst), .i_valid(iv[2]), .i_ready(ir[2]), .lhs(lhs),
    .o_valid(ov[2]), .o_ready(ordy[2]), .o(ow[2]));

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = SBOX[w[8*k +: 8]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One word through DUT d: accept, wait for result with random o_ready noise, stall, then drain.
  task automatic round_trip(input int d, input logic [31:0] w);
    int lat;
    int cyc;
    int stall;
    lat = (d == 0) ? 4 : (d == 1) ? 2 : 1;
    chk("rt_ready_before", {31'd0, ir[d]}, 32'd1);
    lhs   = sub_word(w);
    iv[d] = 1'b1;
    ordy[d] = 1'($urandom_range(0, 1));
    tick();
    iv[d] = 1'b0;
    lhs   = $urandom;
    cyc = 0;
    while (!ov[d] && cyc < 10) begin
      ordy[d] = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    ordy[d] = 1'b0;
    chk("rt_latency", 32'(cyc), 32'(lat));
    stall = $urandom_range(0, 3);
    for (int s = 0; s < stall; s++) begin
      iv[d] = 1'($urandom_range(0, 1));
      tick();
    end
    iv[d] = 1'b0;
    chk("rt_valid_held", {31'd0, ov[d]}, 32'd1);
    chk("rt_data", ow[d], w);
    ordy[d] = 1'b1;
    tick();
    ordy[d] = 1'b0;
    chk("rt_valid_drop", {31'd0, ov[d]}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1;
    lhs = 32'h0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0;
      ordy[d] = 1'b0;
    end

    // Reset state.
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      chk("rst_i_ready", {31'd0, ir[d]}, 32'd0);
      chk("rst_o_valid", {31'd0, ov[d]}, 32'd0);
      chk("rst_o", ow[d], 32'h0);
    end
    rst = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) chk("rel_i_ready", {31'd0, ir[d]}, 32'd1);

    // Basic vector and latency sweep: bytes {63,7c,ed,16} -> {00,01,53,ff}.
    lhs = 32'h16ed7c63;
    for (int d = 0; d < 3; d++) iv[d] = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0;
      chk("acc_i_ready_low", {31'd0, ir[d]}, 32'd0);
    end
    lhs = 32'hdeadbeef;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("lat_bpc1", {31'd0, ov[0]}, {31'd0, k == 4});
      chk("lat_bpc2", {31'd0, ov[1]}, {31'd0, k >= 2});
      chk("lat_bpc4", {31'd0, ov[2]}, 32'd1);
    end
    for (int d = 0; d < 3; d++) chk("basic_o", ow[d], 32'hff530100);

    // Backpressure: DONE holds for 10 cycles with i_valid high and lhs toggling.
    for (int d = 0; d < 3; d++) iv[d] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      lhs = ~lhs;
      tick();
      chk("bp_o_valid", {31'd0, ov[0]}, 32'd1);
      chk("bp_i_ready", {31'd0, ir[0]}, 32'd0);
      chk("bp_o", ow[0], 32'hff530100);
    end
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0;
      ordy[d] = 1'b1;
    end
    tick();
    for (int d = 0; d < 3; d++) begin
      ordy[d] = 1'b0;
      chk("bp_exit_valid", {31'd0, ov[d]}, 32'd0);
      chk("bp_exit_ready", {31'd0, ir[d]}, 32'd1);
      chk("bp_o_retained", ow[d], 32'hff530100);
    end

    // Reset mid-SUB on the 1-byte DUT at idx = 2.
    lhs = 32'h16ed7c63;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    ordy[0] = 1'b1;
    tick();
    chk("mid_rst_valid", {31'd0, ov[0]}, 32'd0);
    chk("mid_rst_o", ow[0], 32'h0);
    chk("mid_rst_ready", {31'd0, ir[0]}, 32'd0);
    rst = 1'b0;
    ordy[0] = 1'b0;
    tick();
    chk("mid_rel_ready", {31'd0, ir[0]}, 32'd1);
    chk("mid_rel_valid", {31'd0, ov[0]}, 32'd0);
    lhs = 32'h00000000;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("post_rst_lat", {31'd0, ov[0]}, {31'd0, k == 4});
    end
    chk("post_rst_o", ow[0], 32'h52525252);
    held = ow[0];
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    chk("post_rst_retain", ow[0], held);

    // Round trip through the forward S-box.
    for (int i = 0; i < 1000; i++) round_trip(0, $urandom);
    for (int i = 0; i < 100; i++) round_trip(1, $urandom);
    for (int i = 0; i < 100; i++) round_trip(2, $urandom);
    round_trip(0, 32'h00000000);
    round_trip(0, 32'hffffffff);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
